rr_arb_mux: RTL

- Parametrised successor to the combinational channel selector.
- Takes N input channels of M-bit data, each with a valid/ready handshake.
- Arbitrates among the valid channels by round-robin or fixed priority, then forwards the winner through one output register stage with its own valid/ready handshake.
- Sits between multiple producers (register-file read ports, ALU/load result sources) and a single shared consumer, such as a writeback bus.

---
 rtl/rr_arb_mux.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel valid/ready arbiter feeding one registered output stage.
//
// Grant is combinational from in_valid and the round-robin pointer (RR=1) or
// plain lowest-index priority (RR=0). The winner is captured into a single
// output register with its own valid/ready handshake. A new beat is loaded
// whenever the register is empty or draining in the same cycle, so sustained
// throughput is one beat per clock.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   in       [N*M-1:0]   packed channel data, channel i at in[M*i +: M]
//   in_valid [N-1:0]     per-channel request
//   in_last  [N-1:0]     end-of-packet marker (packet lock build only)
//   in_ready [N-1:0]     per-channel accept, one-hot or zero
//   out      [M-1:0]     registered data of the selected channel
//   out_valid            out holds an unconsumed beat
//   out_ready            consumer takes out this cycle
//   out_sel  [SW-1:0]    channel index that produced out
//
// Optional feature, macro RR_ARB_MUX_PACKET_LOCK_EN: once a beat with
// in_last=0 is accepted, arbitration locks onto that channel until its
// in_last=1 beat is accepted. The round-robin pointer only moves on that
// closing beat, so a multi-beat packet counts as one turn.
module rr_arb_mux #(
    parameter  int N  = 4,
    parameter  int M  = 8,
    parameter  int RR = 1,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N*M-1:0] in,
    input  logic [N-1:0]   in_valid,
`ifdef RR_ARB_MUX_PACKET_LOCK_EN
    input  logic [N-1:0]   in_last,
`endif
    output logic [N-1:0]   in_ready,
    output logic [M-1:0]   out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  out_sel
);

    logic [M-1:0]  out_q, out_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          vld_q, vld_d;
    logic [N-1:0]  grant;
    logic [SW-1:0] gnt_idx;
    logic [M-1:0]  gnt_data;
    logic          found;
    logic          load_en;
    logic          accept;
    int            cand;

`ifdef RR_ARB_MUX_PACKET_LOCK_EN
    logic          lock_q, lock_d;
    logic [SW-1:0] lock_ch_q, lock_ch_d;
    logic          gnt_last;
    assign gnt_last = |(in_last & grant);
`endif

    assign load_en = !vld_q || out_ready;
    assign accept  = load_en && found;

    // Grant search. Candidate order starts one past the last winner (RR=1)
    // or at channel 0 (RR=0); the first valid candidate wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
`ifdef RR_ARB_MUX_PACKET_LOCK_EN
        if (lock_q) begin
            for (int i = 0; i < N; i++) begin
                if (SW'(i) == lock_ch_q && in_valid[i]) begin
                    grant[i] = 1'b1;
                    gnt_idx  = SW'(i);
                    found    = 1'b1;
                end
            end
        end else
`endif
        begin
            for (int k = 0; k < N; k++) begin
                cand = (RR != 0) ? (int'(ptr_q) + 1 + k) % N : k;
                for (int i = 0; i < N; i++) begin
                    if (!found && i == cand && in_valid[i]) begin
                        grant[i] = 1'b1;
                        gnt_idx  = SW'(i);
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++)
            if (grant[i]) gnt_data = in[i*M +: M];
    end

    assign in_ready = {N{load_en}} & grant;

    always_comb begin
        out_d = out_q;
        sel_d = sel_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
`ifdef RR_ARB_MUX_PACKET_LOCK_EN
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
`endif
        if (accept) begin
            out_d = gnt_data;
            sel_d = gnt_idx;
            vld_d = 1'b1;
`ifdef RR_ARB_MUX_PACKET_LOCK_EN
            lock_d    = !gnt_last;
            lock_ch_d = gnt_idx;
            if (RR != 0 && gnt_last) ptr_d = gnt_idx;
`else
            if (RR != 0) ptr_d = gnt_idx;
`endif
        end else if (load_en) begin
            // Draining with nothing to replace it; data and sel keep last values.
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '0;
            sel_q <= '0;
            vld_q <= 1'b0;
            ptr_q <= SW'(N - 1);
`ifdef RR_ARB_MUX_PACKET_LOCK_EN
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
`endif
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
`ifdef RR_ARB_MUX_PACKET_LOCK_EN
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_sel   = sel_q;
    assign out_valid = vld_q;

endmodule
